bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter. It is the decode side for the BCD counters and BCD displays in the codebase.
- Accepts a packed multi-digit BCD word on a start pulse and runs reverse double-dabble, one bit per clock.
- Presents the binary result with a one-cycle done pulse.
- Sits between BCD count/entry logic and binary arithmetic or compare logic.

Parameters:
- DIGITS, 3, number of BCD digits in bcd_in (each digit 4 bits).
- BIN_W, 10, binary result width. Must satisfy 2^BIN_W > 10^DIGITS - 1; default holds 999.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion of bcd_in; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0]; sampled on accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when result/err valid.
- err  output  1  invalid-digit flag, valid only with done.
- bin_out  output  BIN_W  converted value; held until next done.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE; busy=0, done=0, err=0, bin_out=0; shift regs and iteration counter cleared. Reset wins over all other inputs, including mid-conversion; any in-flight conversion is discarded with no done.
- States:
  - IDLE: busy=0. On start=1 at edge k:
    - If any digit of bcd_in > 9 (with the optional feature compiled in): go to IDLE. done=1 and err=1 during cycle after edge k. bin_out unchanged.
    - Else: load bcd_sr <= bcd_in, bin_sr <= 0, cnt <= BIN_W, go to CONV. busy=1 from cycle after edge k.
  - CONV: each edge performs one iteration on the concatenation {bcd_sr, bin_sr}:
    - Logical shift right by 1; bcd_sr bit 0 enters bin_sr MSB.
    - Then each 4-bit digit of the shifted bcd_sr that is >= 8 has 3 subtracted (per-digit, 4-bit, no borrow between digits).
    - cnt decrements by 1. On the edge where cnt goes 1->0: bin_out <= final bin_sr, done=1, err=0, busy=0, state=IDLE.
- Latency: start accepted at edge k -> done high in the cycle following edge k+BIN_W (10 cycles for defaults). busy high for exactly BIN_W cycles.
- Throughput: start is ignored while busy=1; no queuing. start may be asserted in the same cycle as done (state already IDLE) and is accepted, giving back-to-back conversions every BIN_W+1 cycles.
- done and err are always single-cycle pulses. err=1 only when done=1.
- bcd_in may change freely after the accepting edge.
- Width: BIN_W iterations exactly. No overflow detection beyond the parameter constraint.

Optional Feature:
- Macro: BCD2BIN_CHECK_EN.
- Defined: digit-validity check in IDLE as above. Invalid input returns done+err after 1 cycle, no conversion, bin_out unchanged.
- Undefined: no check. err tied 0. All inputs are converted by the same algorithm, with standard BIN_W-cycle latency. The result for invalid digits is the deterministic algorithm output; the bench checks only timing.

Test Plan:
- Reset, then start with bcd_in=12'h999 -> busy high 10 cycles; done pulse after edge k+10; bin_out=10'd999, err=0.
- Start with bcd_in=12'h000, then 12'h409, the second start asserted in the done cycle of the first -> bin_out=0, then 409. Second done exactly 11 cycles after first.
- Start with 12'h255, and pulse start again with 12'h100 at cycle 4 of busy -> second start ignored; single done with bin_out=255.
- BCD2BIN_CHECK_EN defined, start with 12'h3A5 after a prior result of 255 -> done=1, err=1 one cycle after start; bin_out stays 255; busy never rises.
- Start with 12'h512, assert rst at cycle 5 of busy -> next cycle busy=0, bin_out=0; no done pulse; a new start with 12'h007 yields 7 after 10 cycles.
- Sweep 000..999 back-to-back -> every bin_out equals the decimal value of its bcd_in; err never set.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// rtl/bcd_to_bin_if.sv - start/result handshake bundle for the bcd_to_bin converter
interface bcd_to_bin_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                busy;
  logic                done;
  logic                err;
  logic [BIN_W-1:0]    bin_out;

  // requester side: issues start/bcd_in, consumes the result
  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  err,
    input  bin_out
  );

  // converter side
  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output err,
    output bin_out
  );
endinterface

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD-to-binary converter (reverse double-dabble); optional digit check via BCD2BIN_CHECK_EN
module bcd_to_bin #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic         clk,
  input  logic         rst,
  bcd_to_bin_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t           state, state_nx;
  logic [BCD_W-1:0] bcd_sr, bcd_sr_nx, bcd_step;
  logic [BIN_W-1:0] bin_sr, bin_sr_nx, bin_step;
  logic [BIN_W-1:0] bin_out_r, bin_out_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             done_r, done_nx;
  logic             err_r, err_nx;
  logic             reject;

`ifdef BCD2BIN_CHECK_EN
  // flag a request carrying any digit above 9 so it is refused without converting
  always_comb begin
    reject = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) begin
        reject = 1'b1;
      end
    end
  end
`else
  assign reject = 1'b0;
`endif

  // one iteration: shift {bcd_sr, bin_sr} right, then pull 3 out of every digit that reached 8
  always_comb begin
    bcd_step = {1'b0, bcd_sr[BCD_W-1:1]};
    bin_step = {bcd_sr[0], bin_sr[BIN_W-1:1]};
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_step[4*i +: 4] >= 4'd8) begin
        bcd_step[4*i +: 4] = bcd_step[4*i +: 4] - 4'd3;
      end
    end
  end

  // next-state and next-output decisions; done/err default low so they only ever pulse
  always_comb begin
    state_nx   = state;
    bcd_sr_nx  = bcd_sr;
    bin_sr_nx  = bin_sr;
    cnt_nx     = cnt;
    bin_out_nx = bin_out_r;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (reject) begin
            done_nx = 1'b1;
            err_nx  = 1'b1;
          end else begin
            bcd_sr_nx = bus.bcd_in;
            bin_sr_nx = '0;
            cnt_nx    = CNT_W'(BIN_W);
            state_nx  = CONV;
          end
        end
      end
      CONV: begin
        bcd_sr_nx = bcd_step;
        bin_sr_nx = bin_step;
        cnt_nx    = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bin_out_nx = bin_step;
          done_nx    = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register and datapath; reset discards any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcd_sr    <= '0;
      bin_sr    <= '0;
      cnt       <= '0;
      bin_out_r <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state     <= state_nx;
      bcd_sr    <= bcd_sr_nx;
      bin_sr    <= bin_sr_nx;
      cnt       <= cnt_nx;
      bin_out_r <= bin_out_nx;
      done_r    <= done_nx;
      err_r     <= err_nx;
    end
  end

  assign bus.busy    = (state == CONV);
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.bin_out = bin_out_r;
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - randomized self-checking bench for bcd_to_bin against a decimal reference model
module tb_bcd_to_bin;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
`ifdef BCD2BIN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_res;
  bit   mon_en = 1'b0;
  logic done_q = 1'b0;

  bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference: decimal value of a BCD word
  function automatic int bcd_value(input logic [4*DIGITS-1:0] v);
    int sum = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      sum += int'(v[4*i +: 4]) * p;
      p *= 10;
    end
    return sum;
  endfunction

  function automatic bit has_bad(input logic [4*DIGITS-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  // protocol watch: err only with done, done never two cycles wide
  always @(negedge clk) begin
    if (mon_en) begin
      check("err_without_done", bus.err & ~bus.done, 0);
      check("done_width", bus.done & done_q, 0);
    end
    done_q = bus.done;
  end

  // caller sits at a negedge; returns at the negedge of the cycle after the accepting edge
  task automatic issue(input logic [11:0] v);
    bus.start  = 1'b1;
    bus.bcd_in = v;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = 12'($urandom);
  endtask

  task automatic wait_done(input int inj_at, input logic [11:0] inj_v, output int m, output int busy_n);
    m = 0;
    busy_n = 0;
    while (!bus.done && m < 40) begin
      busy_n += int'(bus.busy);
      if (m == inj_at) begin
        bus.start  = 1'b1;
        bus.bcd_in = inj_v;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      m++;
    end
    bus.start = 1'b0;
    if (!bus.done) check("done_timeout", bus.done, 1);
  endtask

  task automatic conv_check(input logic [11:0] v, input int inj_at, input logic [11:0] inj_v, output int t_done);
    int m;
    int bn;
    bit rej;
    rej = CHECK_EN && has_bad(v);
    issue(v);
    wait_done(inj_at, inj_v, m, bn);
    t_done = cyc;
    check("latency", m, rej ? 0 : BIN_W);
    check("busy_cycles", bn, rej ? 0 : BIN_W);
    check("err", bus.err, rej);
    if (rej) begin
      check("bin_held", bus.bin_out, last_res);
    end else if (!has_bad(v)) begin
      check("bin_out", bus.bin_out, bcd_value(v));
      last_res = bcd_value(v);
    end else begin
      last_res = -1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t1, t2, extra, tprev;
    logic [11:0] v;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_bin", bus.bin_out, 0);
    rst = 1'b0;
    last_res = 0;
    mon_en = 1'b1;
    @(negedge clk);

    conv_check(12'h999, -1, '0, t1);

    @(negedge clk);
    conv_check(12'h000, -1, '0, t1);
    conv_check(12'h409, -1, '0, t2);
    check("b2b_spacing", t2 - t1, BIN_W + 1);

    @(negedge clk);
    conv_check(12'h255, 3, 12'h100, t1);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      extra += int'(bus.done);
    end
    check("ignored_start_done", extra, 0);

    conv_check(12'h3A5, -1, '0, t1);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      extra += int'(bus.busy);
    end
    check("busy_after_invalid", extra, 0);

    issue(12'h512);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_bin", bus.bin_out, 0);
    check("midrst_done", bus.done, 0);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      extra += int'(bus.done);
    end
    check("midrst_no_done", extra, 0);
    last_res = 0;
    conv_check(12'h007, -1, '0, t1);

    @(negedge clk);
    tprev = 0;
    for (int n = 0; n < 1000; n++) begin
      conv_check(to_bcd(n), -1, '0, t1);
      if (n > 0) check("sweep_spacing", t1 - tprev, BIN_W + 1);
      tprev = t1;
    end

    for (int i = 0; i < 200; i++) begin
      int pos;
      int inj;
      v = to_bcd(int'($urandom_range(0, 999)));
      if ($urandom_range(0, 7) == 0) begin
        pos = int'($urandom_range(0, DIGITS - 1));
        v[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, BIN_W - 1)) : -1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      conv_check(v, inj, 12'($urandom), t1);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
